// File: rtl/srmc_pkg.sv
// Shared AES constants, the GF(2^8) xtime helper and the round-tracker state type.
package srmc_pkg;

   localparam int          AES_NR  = 10;
   localparam logic [7:0]  AES_POLY = 8'h1B;
   localparam int          STATE_W = 128;
   localparam int          RND_W   = 4;

   localparam logic [RND_W-1:0] RND_LAST = RND_W'(AES_NR);

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } rnd_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/srmc_mix_column.sv
// One AES MixColumns column: rows 0..3 map to bits [31:24]..[7:0], purely combinational.
module mix_column
   import srmc_pkg::*;
(
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);

   logic [7:0] a0, a1, a2, a3;

   assign a0 = col_in[31:24];
   assign a1 = col_in[23:16];
   assign a2 = col_in[15:8];
   assign a3 = col_in[7:0];

   // xtime is linear, so 2x ^ 3y folds into xtime(x ^ y) ^ y.
   assign col_out[31:24] = xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3;
   assign col_out[23:16] = xtime(a1 ^ a2) ^ a0 ^ a2 ^ a3;
   assign col_out[15:8]  = xtime(a2 ^ a3) ^ a0 ^ a1 ^ a3;
   assign col_out[7:0]   = xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2;

endmodule

// File: rtl/srmc.sv
// AES ShiftRows + MixColumns round stage with round tracking and a one-entry
// valid/ready output register feeding AddRoundKey.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | rnd == 0, no block in flight; only an is_first beat is legal
// ST_ACTIVE | rnd in 1..10, next non-first beat is processed as round rnd
module srmc
   import srmc_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [STATE_W:1]   plain_sub,
   input  logic               ok_sub,
   input  logic               is_first,
   output logic               ready_sub,
   output logic [STATE_W:1]   plain_mc,
   output logic               ok_mc,
   input  logic               ready_mc,
   output logic [RND_W-1:0]   rnd_mc,
   output logic               last_mc,
   output logic               err
);

   logic [STATE_W:1] sr_state;
   logic [STATE_W:1] mc_state;

   // Byte k sits at [128-8k -: 8]; row = k%4, column = k/4.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int KO = 4 * c + r;
         localparam int KI = 4 * ((c + r) % 4) + r;
         assign sr_state[STATE_W - 8*KO -: 8] = plain_sub[STATE_W - 8*KI -: 8];
      end

      mix_column u_mix (
         .col_in  (sr_state[STATE_W - 32*c -: 32]),
         .col_out (mc_state[STATE_W - 32*c -: 32])
      );
   end

   logic [RND_W-1:0]  rnd, rnd_nxt;
   rnd_state_e        state;
   logic              accept;
   logic              capture;
   logic              err_nxt;
   logic [STATE_W:1]  data_nxt;
   logic [RND_W-1:0]  rnd_cap;
   logic              last_cap;

   assign ready_sub = ~ok_mc | ready_mc;
   assign accept    = ok_sub & ready_sub;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rnd <= '0;
         err <= 1'b0;
      end else begin
         rnd <= rnd_nxt;
         err <= err_nxt;
      end
   end

   always_comb begin
      state    = (rnd == '0) ? ST_IDLE : ST_ACTIVE;
      rnd_nxt  = rnd;
      capture  = 1'b0;
      err_nxt  = 1'b0;
      data_nxt = mc_state;
      rnd_cap  = rnd;
      last_cap = 1'b0;
      if (accept) begin
         if (is_first) begin
            capture  = 1'b1;
            data_nxt = plain_sub;
            rnd_cap  = '0;
            rnd_nxt  = RND_W'(1);
         end else begin
            case (state)
               ST_IDLE: begin
                  err_nxt = 1'b1;
               end
               ST_ACTIVE: begin
                  capture = 1'b1;
                  if (rnd == RND_LAST) begin
                     data_nxt = sr_state;
                     last_cap = 1'b1;
                     rnd_nxt  = '0;
                  end else begin
                     rnd_nxt  = rnd + RND_W'(1);
                  end
               end
               default: begin
                  rnd_nxt = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         plain_mc <= '0;
         ok_mc    <= 1'b0;
         rnd_mc   <= '0;
         last_mc  <= 1'b0;
      end else if (capture) begin
         plain_mc <= data_nxt;
         ok_mc    <= 1'b1;
         rnd_mc   <= rnd_cap;
         last_mc  <= last_cap;
      end else if (ready_mc) begin
         ok_mc    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_srmc.sv
// Directed bench for srmc: known AES round vectors, round sequencing,
// backpressure, protocol error recovery and asynchronous reset.
module tb_srmc;

   logic         clk;
   logic         rst_n;
   logic [128:1] plain_sub;
   logic         ok_sub;
   logic         is_first;
   logic         ready_sub;
   logic [128:1] plain_mc;
   logic         ok_mc;
   logic         ready_mc;
   logic [3:0]   rnd_mc;
   logic         last_mc;
   logic         err;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [127:0] VEC_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] VEC_R1  = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] VEC_R10 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] COL_IN  = 128'hdb000000_00130000_00005300_00000045;
   localparam logic [127:0] COL_OUT = 128'h8e4da1bc_00000000_00000000_00000000;
   localparam logic [127:0] PASS_A  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] PASS_B  = 128'hfedcba98765432100123456789abcdef;

   srmc dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .plain_sub (plain_sub),
      .ok_sub    (ok_sub),
      .is_first  (is_first),
      .ready_sub (ready_sub),
      .plain_mc  (plain_mc),
      .ok_mc     (ok_mc),
      .ready_mc  (ready_mc),
      .rnd_mc    (rnd_mc),
      .last_mc   (last_mc),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic beat(input logic [127:0] data, input logic first);
      plain_sub = data;
      is_first  = first;
      ok_sub    = 1'b1;
      @(posedge clk);
      #1;
      ok_sub    = 1'b0;
      is_first  = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [127:0] data, input logic [3:0] rnd,
                          input logic last);
      chk({tag, ".ok"},   128'(ok_mc),   128'd1);
      chk({tag, ".data"}, plain_mc,      data);
      chk({tag, ".rnd"},  128'(rnd_mc),  128'(rnd));
      chk({tag, ".last"}, 128'(last_mc), 128'(last));
   endtask

   initial begin
      rst_n     = 1'b0;
      plain_sub = '0;
      ok_sub    = 1'b0;
      is_first  = 1'b0;
      ready_mc  = 1'b1;

      #12;
      chk("rst.ready_sub", 128'(ready_sub), 128'd1);
      chk("rst.ok_mc",     128'(ok_mc),     128'd0);
      chk("rst.plain_mc",  plain_mc,        128'd0);
      chk("rst.rnd_mc",    128'(rnd_mc),    128'd0);
      chk("rst.last_mc",   128'(last_mc),   128'd0);
      chk("rst.err",       128'(err),       128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst.ready_sub", 128'(ready_sub), 128'd1);

      // Full block: first beat, rounds 1..10
      beat(PASS_A, 1'b1);
      chk_out("r0", PASS_A, 4'd0, 1'b0);
      beat(VEC_IN, 1'b0);
      chk_out("r1", VEC_R1, 4'd1, 1'b0);
      beat(COL_IN, 1'b0);
      chk_out("r2col", COL_OUT, 4'd2, 1'b0);
      for (int r = 3; r <= 9; r++) begin
         beat('0, 1'b0);
         chk_out($sformatf("r%0d", r), '0, 4'(r), 1'b0);
      end
      beat(VEC_IN, 1'b0);
      chk_out("r10", VEC_R10, 4'd10, 1'b1);
      @(posedge clk);
      #1;
      chk("drain.ok_mc", 128'(ok_mc), 128'd0);

      // Block is over: a non-first beat is a protocol error
      beat(PASS_B, 1'b0);
      chk("idle_drop.err",   128'(err),   128'd1);
      chk("idle_drop.ok_mc", 128'(ok_mc), 128'd0);
      @(posedge clk);
      #1;
      chk("idle_drop.err_once", 128'(err),   128'd0);
      chk("idle_drop.no_out",   128'(ok_mc), 128'd0);

      // Restart mid-block at round 5
      beat(PASS_A, 1'b1);
      chk_out("rs.r0", PASS_A, 4'd0, 1'b0);
      for (int r = 1; r <= 4; r++) begin
         beat('0, 1'b0);
         chk("rs.rnd", 128'(rnd_mc), 128'(r));
      end
      beat(PASS_B, 1'b1);
      chk_out("rs.restart", PASS_B, 4'd0, 1'b0);
      chk("rs.no_err", 128'(err), 128'd0);
      beat(VEC_IN, 1'b0);
      chk_out("rs.r1", VEC_R1, 4'd1, 1'b0);

      // Backpressure with a pending beat (round 2)
      ready_mc  = 1'b0;
      plain_sub = COL_IN;
      is_first  = 1'b0;
      ok_sub    = 1'b1;
      #1;
      chk("bp.ready_sub", 128'(ready_sub), 128'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp.ready_sub_hold", 128'(ready_sub), 128'd0);
         chk_out("bp.hold", VEC_R1, 4'd1, 1'b0);
      end
      ready_mc = 1'b1;
      #1;
      chk("bp.release_ready", 128'(ready_sub), 128'd1);
      @(posedge clk);
      #1;
      chk_out("bp.r2", COL_OUT, 4'd2, 1'b0);
      plain_sub = '0;
      @(posedge clk);
      #1;
      ok_sub = 1'b0;
      chk_out("bp.r3", '0, 4'd3, 1'b0);

      // Async reset while ok_mc is high
      beat(COL_IN, 1'b0);
      chk_out("ar.r4", COL_OUT, 4'd4, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar.ok_mc",     128'(ok_mc),     128'd0);
      chk("ar.plain_mc",  plain_mc,        128'd0);
      chk("ar.rnd_mc",    128'(rnd_mc),    128'd0);
      chk("ar.last_mc",   128'(last_mc),   128'd0);
      chk("ar.err",       128'(err),       128'd0);
      chk("ar.ready_sub", 128'(ready_sub), 128'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      beat(VEC_IN, 1'b0);
      chk("ar.post_err",   128'(err),   128'd1);
      chk("ar.post_ok_mc", 128'(ok_mc), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
